// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer with one word of output
// buffering plus one word in assembly.
//
// Parameters
//   WIDTH      bits per parallel word (2..32)
//   MSB_FIRST  0: first serial bit lands in pout[0]; 1: in pout[WIDTH-1]
//
// Ports
//   clk         clock, all state updates on rising edge
//   rst_n       asynchronous active-low reset
//   clr         synchronous flush of the partial word (beats a same-edge bit)
//   sin         serial data bit
//   sin_valid   sin carries a bit this cycle
//   sin_ready   block accepts sin this cycle
//   pout        assembled parallel word
//   pout_valid  pout holds an unconsumed word
//   pout_ready  consumer takes pout this cycle
//   bit_cnt     number of bits held in the partial word
//
// Control state (derived, HOLD may coexist with FILLING)
//   state   | meaning
//   EMPTY   | bit_cnt == 0 and pout_valid == 0
//   FILLING | bit_cnt != 0, partial word in assembly
//   HOLD    | pout_valid == 1, completed word waiting for consumer
// Because HOLD overlaps FILLING, the state is carried by bit_cnt and
// pout_valid directly rather than by a single enumerated register.

module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             last;
    logic             accept;
    logic             complete;

    assign last      = (bit_cnt == LAST_CNT);
    // The last bit may only land if the output register is free or being
    // drained this cycle; this is what guarantees no word is overwritten.
    assign sin_ready = ~last | ~pout_valid | pout_ready;
    assign accept    = sin_valid & sin_ready & ~clr;
    assign complete  = accept & last;

    // Shift register with the incoming bit placed at its slot. Bits at and
    // above the slot are stale, but every slot is rewritten before a word
    // completes, so pout only ever sees whole words.
    always_comb begin
        sreg_nxt = sreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == ((MSB_FIRST != 0) ? CW'(WIDTH - 1 - i) : CW'(i))) begin
                sreg_nxt[i] = sin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            bit_cnt <= '0;
        end else if (accept) begin
            sreg    <= sreg_nxt;
            bit_cnt <= last ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout       <= '0;
            pout_valid <= 1'b0;
        end else if (complete) begin
            pout       <= sreg_nxt;
            pout_valid <= 1'b1;
        end else if (pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001: Parameter WIDTH, default 4, is the number of bits per parallel word; legal range is 2..32.
REQ-002: Parameter MSB_FIRST, default 0; 0 means the first serial bit lands in pout[0], 1 means it lands in pout[WIDTH-1].
REQ-003: Port clk, input, 1 bit, is the single clock; all state updates occur on its rising edge.
REQ-004: Port rst_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-005: Port clr, input, 1 bit, is a synchronous flush of the partially assembled word.
REQ-006: Port sin, input, 1 bit, is the serial data bit.
REQ-007: Port sin_valid, input, 1 bit, indicates that sin holds a bit offered this cycle.
REQ-008: Port sin_ready, output, 1 bit, indicates the block accepts sin this cycle.
REQ-009: Port pout, output, WIDTH bits, is the assembled parallel word.
REQ-010: Port pout_valid, output, 1 bit, indicates that pout holds an unconsumed word.
REQ-011: Port pout_ready, input, 1 bit, indicates the consumer takes pout this cycle.
REQ-012: Port bit_cnt, output, ceil(log2(WIDTH+1)) bits, is the number of bits held in the partial word.

Function
REQ-013: A serial bit is accepted on a rising edge where sin_valid and sin_ready are both 1; it is ignored otherwise.
REQ-014: Each accepted bit is placed at index bit_cnt (MSB_FIRST=0) or at index WIDTH-1-bit_cnt (MSB_FIRST=1) of an internal shift register, and bit_cnt increments.
REQ-015: Accepting the WIDTH-th bit copies the complete word into the output register, sets pout_valid on the same edge, and returns bit_cnt to 0, giving 1-cycle latency from the last bit to pout_valid.
REQ-016: A word is consumed on an edge where pout_valid and pout_ready are both 1; pout_valid clears unless a new word completes on that same edge, in which case the new word loads and pout_valid stays 1.
REQ-017: pout and pout_valid hold stable while pout_valid=1 and pout_ready=0.
REQ-018: sin_ready = (bit_cnt != WIDTH-1) | ~pout_valid | pout_ready; a combinational path from pout_ready to sin_ready is permitted, and no word is ever dropped or overwritten.
REQ-019: The block fills the next partial word while a completed word waits in the output register (one word of buffering plus one word in assembly).
REQ-020: clr=1 on an edge forces bit_cnt to 0 and discards the partial word, leaving pout and pout_valid unchanged; clr has priority over a simultaneous bit acceptance, and that bit is dropped.
REQ-021: The control state is EMPTY (bit_cnt=0, pout_valid=0), FILLING (bit_cnt>0), and HOLD (pout_valid=1, which may coexist with FILLING); transitions follow REQ-013 to REQ-020 only.
REQ-022: Bits in the shift register above bit_cnt are don't-care internally, but pout only ever shows fully assembled words.

Reset
REQ-023: rst_n=0 immediately, without a clock, forces bit_cnt=0, pout_valid=0, and pout=0, and discards any partial word.
REQ-024: With rst_n=0, sin_ready follows REQ-018 and evaluates to 1.
REQ-025: Deassertion of rst_n is assumed synchronous to clk externally; the first bit may be accepted on the first rising edge after deassertion.

Verification
REQ-026: WIDTH=4, MSB_FIRST=0, pout_ready=1, bits 1,0,1,1 on consecutive cycles -> after the 4th edge pout=4'b1101, pout_valid=1 for one cycle, bit_cnt=0.
REQ-027: WIDTH=4, MSB_FIRST=1, same bits -> pout=4'b1011.
REQ-028: pout_ready=0, send 7 bits -> first word held; bit_cnt=3 and sin_ready=0; raise pout_ready -> first word consumed, the 8th bit is accepted, and the second word appears on the next edge with no loss.
REQ-029: Word completes on the same edge that pout_ready drains the previous word -> pout_valid stays 1 and pout updates to the new word.
REQ-030: Assert rst_n=0 mid-edge after 2 bits with a word pending -> pout_valid=0, pout=0, bit_cnt=0 without a clock; next 4 bits form a clean word.
REQ-031: clr pulse after 3 bits with sin_valid=1 -> bit_cnt=0 and that bit is dropped; a pending pout is unaffected; the next 4 bits assemble correctly.
